toggle_hs_rx: RTL and testbench

- Receiving end of a two-phase (toggle) handshake. The sender flips req_tgl once per transfer, using a T flip-flop toggled by a one-cycle strobe.
- This block synchronises req_tgl into the clk domain and detects each transition. It captures req_data and presents it on a valid/ready output port.
- It returns an ack_tgl transition when the word is consumed, so the sender may issue the next transfer.
- It sits at clock-domain and module boundaries wherever a toggle-encoded event must be turned back into a pulse or data word.

---
 rtl/toggle_hs_rx_if.sv | 13 +
 rtl/toggle_hs_rx.sv | 50 +++++
 tb/tb_toggle_hs_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/toggle_hs_rx_if.sv
// toggle_hs_rx_if: toggle request/ack pair plus valid/ready output word; master = sender/consumer side, slave = receiver
interface toggle_hs_rx_if #(
  parameter int DATA_W = 8
);
  logic req_tgl;
  logic [DATA_W-1:0] req_data;
  logic ack_tgl;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic out_ready;
  modport master(output req_tgl, req_data, out_ready, input ack_tgl, out_valid, out_data);
  modport slave(input req_tgl, req_data, out_ready, output ack_tgl, out_valid, out_data);
endinterface

// File: rtl/toggle_hs_rx.sv
// toggle_hs_rx: two-phase handshake receiver; hs carries req_tgl/req_data in, ack_tgl back, out_valid/out_data/out_ready word port; evt_count counts transfers, overrun flags toggles seen while a word is held, clear_overrun clears it
module toggle_hs_rx #(
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  toggle_hs_rx_if.slave hs,
  input logic clear_overrun,
  output logic [CNT_W-1:0] evt_count,
  output logic overrun
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic prev_req, ack, valid, tgl_edge;
  logic [DATA_W-1:0] data;
  assign tgl_edge = sync[SYNC_STAGES-1] ^ prev_req;
  assign hs.ack_tgl = ack;
  assign hs.out_valid = valid;
  assign hs.out_data = data;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      prev_req <= 1'b0;
      ack <= 1'b0;
      valid <= 1'b0;
      data <= '0;
      evt_count <= '0;
      overrun <= 1'b0;
      state <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], hs.req_tgl};
      prev_req <= sync[SYNC_STAGES-1];
      overrun <= (tgl_edge && state == HOLD) || (overrun && !clear_overrun);
      if (state == IDLE) begin
        if (tgl_edge) begin
          data <= hs.req_data;
          valid <= 1'b1;
          state <= HOLD;
        end
      end else if (hs.out_ready) begin
        valid <= 1'b0;
        ack <= ~ack;
        evt_count <= evt_count + 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb_toggle_hs_rx: directed scoreboard bench for toggle_hs_rx
module tb_toggle_hs_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_overrun = 1'b0;
  logic [7:0] evt_count;
  logic overrun;
  toggle_hs_rx_if #(.DATA_W(8)) hs();
  toggle_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .hs(hs),
    .clear_overrun(clear_overrun),
    .evt_count(evt_count),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic exp_ack = 1'b0;
  logic [7:0] exp_evt = 8'd0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    if (!reset && hs.out_valid && hs.out_ready) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("accept_data", hs.out_data, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic ticks(int n);
    repeat (n) tick();
  endtask
  task automatic send(logic [7:0] d, bit keep);
    hs.req_data = d;
    hs.req_tgl = ~hs.req_tgl;
    if (keep) exp_q.push_back(d);
  endtask
  task automatic accepted();
    exp_ack = ~exp_ack;
    exp_evt = exp_evt + 8'd1;
  endtask
  task automatic chk_done(string tag);
    chk({tag, "_valid"}, hs.out_valid, 1'b0);
    chk({tag, "_ack"}, hs.ack_tgl, exp_ack);
    chk({tag, "_evt"}, evt_count, exp_evt);
  endtask
  initial begin
    hs.req_tgl = 1'b0;
    hs.req_data = 8'h00;
    hs.out_ready = 1'b0;
    @(negedge clk);
    ticks(3);
    chk("rst_ack", hs.ack_tgl, 1'b0);
    chk("rst_valid", hs.out_valid, 1'b0);
    chk("rst_data", hs.out_data, 8'h00);
    chk("rst_evt", evt_count, 8'd0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    hs.out_ready = 1'b1;
    send(8'hA5, 1);
    tick();
    chk("lat_e1_valid", hs.out_valid, 1'b0);
    tick();
    chk("lat_e2_valid", hs.out_valid, 1'b0);
    tick();
    chk("lat_e3_valid", hs.out_valid, 1'b1);
    chk("lat_e3_data", hs.out_data, 8'hA5);
    chk("lat_e3_ack", hs.ack_tgl, exp_ack);
    tick();
    accepted();
    chk_done("fast");
    hs.out_ready = 1'b0;
    send(8'hA5, 1);
    ticks(3);
    chk("slow_valid", hs.out_valid, 1'b1);
    repeat (5) begin
      tick();
      chk("hold_valid", hs.out_valid, 1'b1);
      chk("hold_data", hs.out_data, 8'hA5);
      chk("hold_ack", hs.ack_tgl, exp_ack);
    end
    hs.out_ready = 1'b1;
    tick();
    accepted();
    chk_done("slow");
    send(8'h3C, 1);
    ticks(3);
    chk("second_data", hs.out_data, 8'h3C);
    tick();
    accepted();
    chk_done("second");
    hs.out_ready = 1'b0;
    send(8'hA5, 1);
    ticks(3);
    chk("ovr_valid", hs.out_valid, 1'b1);
    send(8'hFF, 0);
    ticks(3);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_data", hs.out_data, 8'hA5);
    chk("ovr_ack", hs.ack_tgl, exp_ack);
    hs.out_ready = 1'b1;
    tick();
    accepted();
    chk_done("ovr_accept");
    repeat (4) begin
      tick();
      chk_done("ovr_no_extra");
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("clr_overrun", overrun, 1'b0);
    hs.out_ready = 1'b0;
    send(8'h11, 1);
    ticks(3);
    send(8'h22, 0);
    ticks(2);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("set_wins", overrun, 1'b1);
    tick();
    chk("set_sticky", overrun, 1'b1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("clr_again", overrun, 1'b0);
    hs.out_ready = 1'b1;
    tick();
    accepted();
    chk_done("clr_accept");
    hs.out_ready = 1'b0;
    send(8'h33, 1);
    ticks(3);
    send(8'h44, 0);
    ticks(2);
    hs.out_ready = 1'b1;
    tick();
    accepted();
    chk_done("acc_edge");
    chk("acc_edge_ovr", overrun, 1'b1);
    repeat (4) begin
      tick();
      chk_done("acc_edge_drop");
    end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    reset = 1'b1;
    hs.req_tgl = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_evt = 8'd0;
    chk_done("wrap_start");
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1);
      ticks(4);
      accepted();
      if (i == 254) chk("evt_255", evt_count, exp_evt);
    end
    chk_done("wrap");
    chk("wrap_zero", evt_count, 8'd0);
    send(8'h77, 1);
    ticks(4);
    accepted();
    chk_done("post_wrap");
    hs.out_ready = 1'b0;
    send(8'h5A, 1);
    ticks(3);
    chk("mid_valid", hs.out_valid, 1'b1);
    reset = 1'b1;
    hs.req_tgl = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_evt = 8'd0;
    chk_done("mid_rst");
    ticks(4);
    chk_done("mid_rst_quiet");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
